// File: rtl/s3g_requester.sv
// s3g_requester: host-side S3G initiator; frames and sends a request, then receives and checks the response.
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   req_wr, req_len, req_buf0..15 request start pulse, payload length (1..16), payload bytes
//   busy                          transaction in progress
//   tx_data, tx_wr, tx_done       UART transmit handshake
//   rx_data, rx_done              UART receive byte stream
//   resp_done/error/timeout       one-cycle result pulses
//   resp_len, resp_buf0..15       last valid response
module s3g_requester #(
    parameter logic [31:0] TIMEOUT = 32'd100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_wr,
    input  logic [7:0] req_len,
    input  logic [7:0] req_buf0,
    input  logic [7:0] req_buf1,
    input  logic [7:0] req_buf2,
    input  logic [7:0] req_buf3,
    input  logic [7:0] req_buf4,
    input  logic [7:0] req_buf5,
    input  logic [7:0] req_buf6,
    input  logic [7:0] req_buf7,
    input  logic [7:0] req_buf8,
    input  logic [7:0] req_buf9,
    input  logic [7:0] req_buf10,
    input  logic [7:0] req_buf11,
    input  logic [7:0] req_buf12,
    input  logic [7:0] req_buf13,
    input  logic [7:0] req_buf14,
    input  logic [7:0] req_buf15,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       resp_done,
    output logic       resp_error,
    output logic       resp_timeout,
    output logic [7:0] resp_len,
    output logic [7:0] resp_buf0,
    output logic [7:0] resp_buf1,
    output logic [7:0] resp_buf2,
    output logic [7:0] resp_buf3,
    output logic [7:0] resp_buf4,
    output logic [7:0] resp_buf5,
    output logic [7:0] resp_buf6,
    output logic [7:0] resp_buf7,
    output logic [7:0] resp_buf8,
    output logic [7:0] resp_buf9,
    output logic [7:0] resp_buf10,
    output logic [7:0] resp_buf11,
    output logic [7:0] resp_buf12,
    output logic [7:0] resp_buf13,
    output logic [7:0] resp_buf14,
    output logic [7:0] resp_buf15
);
    typedef enum logic [3:0] {
        IDLE, TX_SYNC, TX_LEN, TX_DATA, TX_CRC, RX_SYNC, RX_LEN, RX_DATA, RX_CRC
    } state_t;

    localparam logic [7:0] SYNC = 8'hD5;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  pay_q [16];
    logic [7:0]  pay_d [16];
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  crc_q, crc_d;
    logic [31:0] timer_q, timer_d;
    logic        busy_q, busy_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_wr_q, tx_wr_d;
    logic        resp_done_q, resp_done_d;
    logic        resp_error_q, resp_error_d;
    logic        resp_timeout_q, resp_timeout_d;
    logic [7:0]  resp_len_q, resp_len_d;
    logic [7:0]  resp_buf_q [16];
    logic [7:0]  resp_buf_d [16];
    logic [7:0]  rx_len_q, rx_len_d;
    logic [7:0]  rxb_q [16];
    logic [7:0]  rxb_d [16];
    logic [7:0]  req_buf [16];
    logic        tx_ack, rx_phase, expired;

    // iButton/Maxim CRC-8, reflected polynomial 0x8C, one byte folded per call
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 8'h8C) : (r >> 1);
        return r;
    endfunction

    assign req_buf = '{req_buf0, req_buf1, req_buf2, req_buf3, req_buf4, req_buf5, req_buf6, req_buf7,
                       req_buf8, req_buf9, req_buf10, req_buf11, req_buf12, req_buf13, req_buf14, req_buf15};

    // A tx_done in the same cycle as tx_wr cannot belong to the byte just issued
    assign tx_ack   = tx_done && !tx_wr_q;
    assign rx_phase = state_q inside {RX_SYNC, RX_LEN, RX_DATA, RX_CRC};
    // A byte arriving on the expiry cycle takes priority and restarts the timer
    assign expired  = rx_phase && !rx_done && (timer_q == TIMEOUT - 32'd1);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        pay_d          = pay_q;
        idx_d          = idx_q;
        crc_d          = crc_q;
        timer_d        = rx_phase ? (rx_done ? 32'd0 : timer_q + 32'd1) : timer_q;
        tx_data_d      = tx_data_q;
        tx_wr_d        = 1'b0;
        resp_done_d    = 1'b0;
        resp_error_d   = 1'b0;
        resp_timeout_d = 1'b0;
        resp_len_d     = resp_len_q;
        resp_buf_d     = resp_buf_q;
        rx_len_d       = rx_len_q;
        rxb_d          = rxb_q;
        case (state_q)
            IDLE: if (req_wr) begin
                if (req_len == 8'd0 || req_len > 8'd16) begin
                    resp_error_d = 1'b1;
                end else begin
                    state_d   = TX_SYNC;
                    len_d     = req_len;
                    pay_d     = req_buf;
                    crc_d     = 8'd0;
                    idx_d     = 4'd0;
                    tx_wr_d   = 1'b1;
                    tx_data_d = SYNC;
                end
            end
            TX_SYNC: if (tx_ack) begin
                state_d   = TX_LEN;
                tx_wr_d   = 1'b1;
                tx_data_d = len_q;
            end
            TX_LEN: if (tx_ack) begin
                state_d   = TX_DATA;
                tx_wr_d   = 1'b1;
                tx_data_d = pay_q[0];
                crc_d     = crc8(crc_q, pay_q[0]);
                idx_d     = 4'd0;
            end
            TX_DATA: if (tx_ack) begin
                tx_wr_d = 1'b1;
                if ({4'd0, idx_q} == len_q - 8'd1) begin
                    state_d   = TX_CRC;
                    tx_data_d = crc_q;
                end else begin
                    idx_d     = idx_q + 4'd1;
                    tx_data_d = pay_q[idx_q + 4'd1];
                    crc_d     = crc8(crc_q, pay_q[idx_q + 4'd1]);
                end
            end
            TX_CRC: if (tx_ack) begin
                state_d = RX_SYNC;
                timer_d = 32'd0;
            end
            RX_SYNC: if (rx_done && rx_data == SYNC) state_d = RX_LEN;
            RX_LEN: if (rx_done) begin
                if (rx_data == 8'd0 || rx_data > 8'd16) begin
                    state_d      = IDLE;
                    resp_error_d = 1'b1;
                end else begin
                    state_d  = RX_DATA;
                    rx_len_d = rx_data;
                    crc_d    = 8'd0;
                    idx_d    = 4'd0;
                end
            end
            RX_DATA: if (rx_done) begin
                rxb_d[idx_q] = rx_data;
                crc_d        = crc8(crc_q, rx_data);
                if ({4'd0, idx_q} == rx_len_q - 8'd1) state_d = RX_CRC;
                else idx_d = idx_q + 4'd1;
            end
            RX_CRC: if (rx_done) begin
                state_d = IDLE;
                if (rx_data == crc_q) begin
                    resp_done_d = 1'b1;
                    resp_len_d  = rx_len_q;
                    resp_buf_d  = rxb_q;
                end else begin
                    resp_error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (expired) begin
            state_d        = IDLE;
            resp_timeout_d = 1'b1;
        end
        // Held through the result pulse cycle, dropping one cycle after it
        busy_d = (state_q != IDLE) || (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            len_q          <= 8'd0;
            pay_q          <= '{default: 8'd0};
            idx_q          <= 4'd0;
            crc_q          <= 8'd0;
            timer_q        <= 32'd0;
            busy_q         <= 1'b0;
            tx_data_q      <= 8'd0;
            tx_wr_q        <= 1'b0;
            resp_done_q    <= 1'b0;
            resp_error_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_len_q     <= 8'd0;
            resp_buf_q     <= '{default: 8'd0};
            rx_len_q       <= 8'd0;
            rxb_q          <= '{default: 8'd0};
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            pay_q          <= pay_d;
            idx_q          <= idx_d;
            crc_q          <= crc_d;
            timer_q        <= timer_d;
            busy_q         <= busy_d;
            tx_data_q      <= tx_data_d;
            tx_wr_q        <= tx_wr_d;
            resp_done_q    <= resp_done_d;
            resp_error_q   <= resp_error_d;
            resp_timeout_q <= resp_timeout_d;
            resp_len_q     <= resp_len_d;
            resp_buf_q     <= resp_buf_d;
            rx_len_q       <= rx_len_d;
            rxb_q          <= rxb_d;
        end
    end

    assign busy         = busy_q;
    assign tx_data      = tx_data_q;
    assign tx_wr        = tx_wr_q;
    assign resp_done    = resp_done_q;
    assign resp_error   = resp_error_q;
    assign resp_timeout = resp_timeout_q;
    assign resp_len     = resp_len_q;
    assign resp_buf0    = resp_buf_q[0];
    assign resp_buf1    = resp_buf_q[1];
    assign resp_buf2    = resp_buf_q[2];
    assign resp_buf3    = resp_buf_q[3];
    assign resp_buf4    = resp_buf_q[4];
    assign resp_buf5    = resp_buf_q[5];
    assign resp_buf6    = resp_buf_q[6];
    assign resp_buf7    = resp_buf_q[7];
    assign resp_buf8    = resp_buf_q[8];
    assign resp_buf9    = resp_buf_q[9];
    assign resp_buf10   = resp_buf_q[10];
    assign resp_buf11   = resp_buf_q[11];
    assign resp_buf12   = resp_buf_q[12];
    assign resp_buf13   = resp_buf_q[13];
    assign resp_buf14   = resp_buf_q[14];
    assign resp_buf15   = resp_buf_q[15];
endmodule

// File: tb/tb_s3g_requester.sv
// tb_s3g_requester: directed bench for s3g_requester with a hand-paced UART model.
module tb_s3g_requester;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_wr = 1'b0;
    logic [7:0] req_len = 8'd0;
    logic [7:0] req_buf [16];
    logic       busy, tx_wr, tx_done = 1'b0, rx_done = 1'b0;
    logic [7:0] tx_data, rx_data = 8'd0, resp_len;
    logic       resp_done, resp_error, resp_timeout;
    logic [7:0] resp_buf [16];
    int passed = 0, total = 0;
    int n_done = 0, n_err = 0, n_to = 0, n_txwr = 0;
    logic [7:0] tx_log [$];

    always #5 clk = ~clk;

    s3g_requester #(.TIMEOUT(32'd100)) dut (
        .clk(clk), .rst(rst), .req_wr(req_wr), .req_len(req_len),
        .req_buf0(req_buf[0]), .req_buf1(req_buf[1]), .req_buf2(req_buf[2]), .req_buf3(req_buf[3]),
        .req_buf4(req_buf[4]), .req_buf5(req_buf[5]), .req_buf6(req_buf[6]), .req_buf7(req_buf[7]),
        .req_buf8(req_buf[8]), .req_buf9(req_buf[9]), .req_buf10(req_buf[10]), .req_buf11(req_buf[11]),
        .req_buf12(req_buf[12]), .req_buf13(req_buf[13]), .req_buf14(req_buf[14]), .req_buf15(req_buf[15]),
        .busy(busy), .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done),
        .resp_done(resp_done), .resp_error(resp_error), .resp_timeout(resp_timeout), .resp_len(resp_len),
        .resp_buf0(resp_buf[0]), .resp_buf1(resp_buf[1]), .resp_buf2(resp_buf[2]), .resp_buf3(resp_buf[3]),
        .resp_buf4(resp_buf[4]), .resp_buf5(resp_buf[5]), .resp_buf6(resp_buf[6]), .resp_buf7(resp_buf[7]),
        .resp_buf8(resp_buf[8]), .resp_buf9(resp_buf[9]), .resp_buf10(resp_buf[10]), .resp_buf11(resp_buf[11]),
        .resp_buf12(resp_buf[12]), .resp_buf13(resp_buf[13]), .resp_buf14(resp_buf[14]), .resp_buf15(resp_buf[15])
    );

    // Each one-cycle pulse is seen exactly once at the falling edge
    always @(negedge clk) begin
        if (tx_wr) begin
            tx_log.push_back(tx_data);
            n_txwr++;
        end
        if (resp_done) n_done++;
        if (resp_error) n_err++;
        if (resp_timeout) n_to++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [7:0] len);
        req_len = len;
        req_wr = 1'b1;
        tick();
        req_wr = 1'b0;
    endtask

    // Answers every tx_wr with tx_done five cycles later; returns right after the last tx_done is sampled
    task automatic serve_tx(input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            for (int w = 0; w < 20 && !tx_wr; w++) tick();
            total++;
            if (tx_wr !== 1'b1) $display("FAIL tx_wr_wait byte %0d: got %b expected 1", k, tx_wr);
            else passed++;
            repeat (5) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    // Request payload 01 02 03 through to the end of the CRC byte
    task automatic do_request();
        req_buf[0] = 8'h01;
        req_buf[1] = 8'h02;
        req_buf[2] = 8'h03;
        pulse_req(8'd3);
        serve_tx(6);
    endtask

    task automatic test_reset();
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (tx_wr !== 1'b0 || tx_data !== 8'h00) $display("FAIL reset_tx: got wr %b data %h expected 0 00", tx_wr, tx_data); else passed++;
        total++; if ({resp_done, resp_error, resp_timeout} !== 3'b000) $display("FAIL reset_pulses: got %b expected 000", {resp_done, resp_error, resp_timeout}); else passed++;
        total++; if (resp_len !== 8'h00 || resp_buf[0] !== 8'h00 || resp_buf[15] !== 8'h00) $display("FAIL reset_resp: got len %h buf0 %h buf15 %h expected 00", resp_len, resp_buf[0], resp_buf[15]); else passed++;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_tx_frame();
        logic [7:0] exp [6];
        exp = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
        tx_log.delete();
        req_buf[0] = 8'h01;
        req_buf[1] = 8'h02;
        req_buf[2] = 8'h03;
        pulse_req(8'd3);
        total++; if (busy !== 1'b1) $display("FAIL start_busy: got %b expected 1", busy); else passed++;
        total++; if (tx_wr !== 1'b1 || tx_data !== 8'hD5) $display("FAIL start_tx: got wr %b data %h expected 1 d5", tx_wr, tx_data); else passed++;
        serve_tx(6);
        total++; if (tx_log.size() !== 6) $display("FAIL tx_count: got %0d expected 6", tx_log.size()); else passed++;
        // iButton CRC-8 of 01 02 03 is 0xD8
        for (int i = 0; i < 6 && i < tx_log.size(); i++) begin
            total++; if (tx_log[i] !== exp[i]) $display("FAIL tx_byte%0d: got %h expected %h", i, tx_log[i], exp[i]); else passed++;
        end
        total++; if (busy !== 1'b1) $display("FAIL tx_busy_held: got %b expected 1", busy); else passed++;
    endtask

    task automatic test_rx_good();
        int d0;
        d0 = n_done;
        send_rx(8'h13);
        send_rx(8'hD5);
        send_rx(8'h03);
        send_rx(8'h01);
        send_rx(8'h02);
        send_rx(8'h03);
        rx_data = 8'hD8;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        total++; if (resp_done !== 1'b1 || busy !== 1'b1) $display("FAIL rx_done_pulse: got done %b busy %b expected 1 1", resp_done, busy); else passed++;
        total++; if (resp_len !== 8'd3) $display("FAIL rx_len: got %0d expected 3", resp_len); else passed++;
        total++; if (resp_buf[0] !== 8'h01 || resp_buf[1] !== 8'h02 || resp_buf[2] !== 8'h03) $display("FAIL rx_buf: got %h %h %h expected 01 02 03", resp_buf[0], resp_buf[1], resp_buf[2]); else passed++;
        tick();
        total++; if (busy !== 1'b0 || resp_done !== 1'b0) $display("FAIL rx_busy_drop: got busy %b done %b expected 0 0", busy, resp_done); else passed++;
        total++; if (n_done - d0 !== 1) $display("FAIL rx_done_count: got %0d expected 1", n_done - d0); else passed++;
    endtask

    task automatic test_rx_len1();
        do_request();
        send_rx(8'hD5);
        send_rx(8'h01);
        send_rx(8'h01);
        send_rx(8'h5E);
        total++; if (resp_len !== 8'd1 || resp_buf[0] !== 8'h01) $display("FAIL len1_resp: got len %0d buf0 %h expected 1 01", resp_len, resp_buf[0]); else passed++;
    endtask

    task automatic test_bad_crc();
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        do_request();
        send_rx(8'hD5);
        send_rx(8'h03);
        send_rx(8'h01);
        send_rx(8'h02);
        send_rx(8'h03);
        send_rx(8'hCC);
        total++; if (n_err - e0 !== 1 || n_done !== d0) $display("FAIL crc_err_count: got err %0d done %0d expected 1 0", n_err - e0, n_done - d0); else passed++;
        total++; if (resp_len !== 8'd1 || resp_buf[0] !== 8'h01 || resp_buf[1] !== 8'h02) $display("FAIL crc_resp_kept: got len %0d buf %h %h expected 1 01 02", resp_len, resp_buf[0], resp_buf[1]); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL crc_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_bad_req_len();
        int t0;
        logic [7:0] lens [2];
        lens = '{8'd0, 8'd17};
        t0 = n_txwr;
        for (int i = 0; i < 2; i++) begin
            pulse_req(lens[i]);
            total++; if (resp_error !== 1'b1 || busy !== 1'b0 || tx_wr !== 1'b0) $display("FAIL bad_req_len%0d: got err %b busy %b wr %b expected 1 0 0", lens[i], resp_error, busy, tx_wr); else passed++;
            repeat (3) tick();
            total++; if (busy !== 1'b0 || n_txwr !== t0) $display("FAIL bad_req_quiet%0d: got busy %b tx %0d expected 0 0", lens[i], busy, n_txwr - t0); else passed++;
        end
    endtask

    task automatic test_bad_resp_len();
        logic [7:0] lens [2];
        lens = '{8'd0, 8'd17};
        for (int i = 0; i < 2; i++) begin
            do_request();
            send_rx(8'hD5);
            rx_data = lens[i];
            rx_done = 1'b1;
            tick();
            rx_done = 1'b0;
            total++; if (resp_error !== 1'b1 || resp_len !== 8'd1) $display("FAIL bad_resp_len%0d: got err %b len %0d expected 1 1", lens[i], resp_error, resp_len); else passed++;
            tick();
        end
    endtask

    task automatic test_timeout();
        int n, t0;
        t0 = n_to;
        do_request();
        n = 0;
        while (n < 300 && !resp_timeout) begin
            tick();
            n++;
        end
        total++; if (n !== 100) $display("FAIL timeout_plain: got %0d cycles expected 100", n); else passed++;
        tick();
        do_request();
        n = 0;
        while (n < 300 && !resp_timeout) begin
            tick();
            n++;
            rx_data = 8'h13;
            rx_done = (n == 59);
        end
        rx_done = 1'b0;
        total++; if (n !== 160) $display("FAIL timeout_restart: got %0d cycles expected 160", n); else passed++;
        tick();
        total++; if (n_to - t0 !== 2 || busy !== 1'b0) $display("FAIL timeout_count: got %0d busy %b expected 2 0", n_to - t0, busy); else passed++;
    endtask

    task automatic test_reset_mid();
        int r0;
        r0 = n_done + n_err + n_to;
        req_buf[0] = 8'h01;
        pulse_req(8'd3);
        serve_tx(2);
        total++; if (tx_wr !== 1'b1 || tx_data !== 8'h01) $display("FAIL mid_pre: got wr %b data %h expected 1 01", tx_wr, tx_data); else passed++;
        #1 rst = 1'b0;
        #1;
        total++; if (tx_wr !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) $display("FAIL mid_clear: got wr %b busy %b data %h expected 0 0 00", tx_wr, busy, tx_data); else passed++;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        pulse_req(8'd3);
        total++; if (tx_wr !== 1'b1 || tx_data !== 8'hD5) $display("FAIL mid_restart: got wr %b data %h expected 1 d5", tx_wr, tx_data); else passed++;
        total++; if (n_done + n_err + n_to !== r0) $display("FAIL mid_no_result: got %0d extra pulses expected 0", n_done + n_err + n_to - r0); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) req_buf[i] = 8'hA0 + 8'(i);
        test_reset();
        test_tx_frame();
        test_rx_good();
        test_rx_len1();
        test_bad_crc();
        test_bad_req_len();
        test_bad_resp_len();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
